wb_port_arbiter: RTL and testbench

//  Shares the single register-file write port among NREQ writeback sources (ALU, FPU, load unit).

---
 rtl/wb_port_arbiter.sv | 103 ++++++++++
 tb/tb_wb_port_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NREQ writeback sources.
// The winning request is registered onto {we, wb_rd, rddata} for exactly one cycle.
module wb_port_arbiter #(
  parameter int NREQ    = 3,
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*RADDR_W-1:0]   req_rd,
  input  logic [NREQ*DATA_W-1:0]    req_data,
  output logic [NREQ-1:0]           req_ready,
  output logic                      we,
  output logic [RADDR_W:0]          wb_rd,
  output logic [DATA_W-1:0]         rddata,
  output logic [63:0]               busy_mask
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   grant_idx;
  logic [IDX_W-1:0]   next_ptr;
  logic [IDX_W-1:0]   scan_idx;
  logic [IDX_W:0]     scan_sum;
  logic               grant_vld;
  logic [RADDR_W-1:0] sel_rd;
  logic [DATA_W-1:0]  sel_data;

  logic               vld_p1;
  logic [RADDR_W:0]   wb_rd_p1;
  logic [DATA_W-1:0]  rddata_p1;
  logic [63:0]        busy_p1;

  // Stage 0: circular priority search starting at rr_ptr
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (scan_sum >= (IDX_W+1)'(NREQ))
        scan_sum = scan_sum - (IDX_W+1)'(NREQ);
      scan_idx = scan_sum[IDX_W-1:0];
      if (!grant_vld && req_valid[scan_idx]) begin
        grant_vld = 1'b1;
        grant_idx = scan_idx;
      end
    end
    if (stall || rst)
      grant_vld = 1'b0;
  end

  always_comb begin
    req_ready = '0;
    sel_rd    = '0;
    sel_data  = '0;
    if (grant_vld)
      req_ready[grant_idx] = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_vld && grant_idx == IDX_W'(i)) begin
        sel_rd   = req_rd[i*RADDR_W +: RADDR_W];
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign next_ptr = (grant_idx == IDX_W'(NREQ-1)) ? '0 : grant_idx + 1'b1;

  // Stage 1: registered write port; x0 writes are accepted but never reach the port
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr    <= '0;
      vld_p1    <= 1'b0;
      wb_rd_p1  <= '0;
      rddata_p1 <= '0;
      busy_p1   <= '0;
    end else begin
      if (grant_vld)
        rr_ptr <= next_ptr;
      if (grant_vld && sel_rd != '0) begin
        vld_p1    <= 1'b1;
        wb_rd_p1  <= {1'b1, sel_rd};
        rddata_p1 <= sel_data;
        busy_p1   <= 64'(1) << sel_rd;
      end else begin
        vld_p1    <= 1'b0;
        wb_rd_p1  <= '0;
        rddata_p1 <= '0;
        busy_p1   <= '0;
      end
    end
  end

  assign we        = vld_p1;
  assign wb_rd     = wb_rd_p1;
  assign rddata    = rddata_p1;
  assign busy_mask = busy_p1;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: grant order, write-port latency, x0 suppression,
// float destinations, stall hold and mid-operation reset.
module tb_wb_port_arbiter;
  localparam int NREQ = 3;
  localparam int DW   = 32;
  localparam int RW   = 6;

  logic               clk = 1'b0;
  logic               rst;
  logic               stall;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*RW-1:0] req_rd;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               we;
  logic [RW:0]        wb_rd;
  logic [DW-1:0]      rddata;
  logic [63:0]        busy_mask;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  wb_port_arbiter #(.NREQ(NREQ), .DATA_W(DW), .RADDR_W(RW)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data),
    .req_ready(req_ready), .we(we), .wb_rd(wb_rd), .rddata(rddata),
    .busy_mask(busy_mask)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_src(input int i, input logic [RW-1:0] rd, input logic [DW-1:0] data);
    req_rd[i*RW +: RW]   = rd;
    req_data[i*DW +: DW] = data;
  endtask

  task automatic chk_port(input string tag, input logic e_we, input logic [RW:0] e_rd,
                          input logic [DW-1:0] e_data, input logic [63:0] e_busy);
    chk({tag, "_we"}, 64'(we), 64'(e_we));
    chk({tag, "_wb_rd"}, 64'(wb_rd), 64'(e_rd));
    chk({tag, "_rddata"}, 64'(rddata), 64'(e_data));
    chk({tag, "_busy"}, busy_mask, e_busy);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; req_valid = '0; req_rd = '0; req_data = '0;
    tick(); tick();
    // reset state; no grant while rst even with requests pending
    req_valid = 3'b111;
    #1;
    chk("rst_ready", 64'(req_ready), 64'(0));
    chk_port("rst", 1'b0, 7'h00, 32'h0, 64'h0);

    // 1: single source, rd=5
    rst = 1'b0; req_valid = 3'b001;
    set_src(0, 6'd5, 32'hDEADBEEF);
    #1;
    chk("t1_ready", 64'(req_ready), 64'(3'b001));
    tick();
    req_valid = '0;
    chk_port("t1_c2", 1'b1, 7'h45, 32'hDEADBEEF, 64'h1 << 5);
    tick();
    chk_port("t1_c3", 1'b0, 7'h00, 32'h0, 64'h0);

    // 2: all valid from reset -> 0,1,2,0,1,2
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_src(0, 6'd1, 32'h100);
    set_src(1, 6'd2, 32'h101);
    set_src(2, 6'd3, 32'h102);
    req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("t2_ready", 64'(req_ready), 64'(3'b001 << (k % 3)));
      tick();
      chk("t2_we", 64'(we), 64'(1));
      chk("t2_wb_rd", 64'(wb_rd), 64'(7'h40 | 7'((k % 3) + 1)));
      chk("t2_rddata", 64'(rddata), 64'(32'h100 + 32'(k % 3)));
    end
    req_valid = '0;
    tick();
    chk_port("t2_idle", 1'b0, 7'h00, 32'h0, 64'h0);

    // 3: rd=0 from source 1 is accepted but not written
    set_src(1, 6'd0, 32'h55555555);
    req_valid = 3'b010;
    #1;
    chk("t3_ready", 64'(req_ready), 64'(3'b010));
    tick();
    chk_port("t3_x0", 1'b0, 7'h00, 32'h0, 64'h0);
    set_src(1, 6'd2, 32'h101);
    req_valid = 3'b111;
    #1;
    chk("t3_tie", 64'(req_ready), 64'(3'b100));
    tick();
    req_valid = '0;
    chk("t3_tie_rd", 64'(wb_rd), 64'(7'h43));

    // 4: float destination rd=40
    set_src(0, 6'd40, 32'h3F800000);
    req_valid = 3'b001;
    #1;
    chk("t4_ready", 64'(req_ready), 64'(3'b001));
    tick();
    req_valid = '0;
    chk_port("t4", 1'b1, 7'h68, 32'h3F800000, 64'h1 << 40);

    // 5: stall with sources 0 and 2 valid (rr_ptr=1 -> source 2 first)
    set_src(0, 6'd1, 32'h100);
    req_valid = 3'b101;
    #1;
    chk("t5_pre", 64'(req_ready), 64'(3'b100));
    tick();
    stall = 1'b1;
    chk("t5_inflight_we", 64'(we), 64'(1));
    chk("t5_inflight_rd", 64'(wb_rd), 64'(7'h43));
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t5_stall_ready", 64'(req_ready), 64'(0));
      tick();
      chk("t5_stall_we", 64'(we), 64'(0));
    end
    stall = 1'b0;
    #1;
    chk("t5_resume0", 64'(req_ready), 64'(3'b001));
    tick();
    chk("t5_resume0_rd", 64'(wb_rd), 64'(7'h41));
    #1;
    chk("t5_resume1", 64'(req_ready), 64'(3'b100));
    tick();
    chk("t5_resume1_rd", 64'(wb_rd), 64'(7'h43));

    // 6: rst in the cycle after a transfer (rr_ptr left at 1 beforehand)
    req_valid = 3'b001;
    #1;
    chk("t6_ready", 64'(req_ready), 64'(3'b001));
    tick();
    chk("t6_port_we", 64'(we), 64'(1));
    rst = 1'b1;
    #1;
    chk("t6_rst_ready", 64'(req_ready), 64'(0));
    tick();
    chk_port("t6_drop", 1'b0, 7'h00, 32'h0, 64'h0);
    rst = 1'b0;
    req_valid = 3'b011;
    #1;
    chk("t6_post_ready", 64'(req_ready), 64'(3'b001));
    tick();
    req_valid = '0;
    chk_port("t6_post", 1'b1, 7'h41, 32'h100, 64'h1 << 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
